// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-to-serial MISO driver: loads a read word and shifts it out MSB first.
module spi_tx_serializer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              done
);

  logic [DATA_W-1:0] sh;
  logic [CNT_W-1:0]  rem;
  logic              busy;

  // High on the edge that retires the last bit and returns MISO to 0.
  assign done = busy && (rem == '0);

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      miso <= 1'b0;
      sh   <= '0;
      rem  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      miso <= data[DATA_W-1];
      sh   <= data << 1;
      rem  <= CNT_W'(DATA_W-1);
      busy <= 1'b1;
    end else if (busy) begin
      if (rem == '0) begin
        miso <= 1'b0;
        busy <= 1'b0;
      end else begin
        miso <= sh[DATA_W-1];
        sh   <= sh << 1;
        rem  <= rem - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserializes MOSI command frames and returns RAM read data on MISO.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W+1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W:0]  shreg;
  logic             rd_addr_seen;
  logic             rx_done;
  logic             wait_tx;
  logic             tx_load;
  logic             tx_last;

  // Reply is accepted only while a read-data frame is waiting and the master still selects us.
  assign tx_load = (state == READ_DATA) && rx_done && wait_tx && tx_valid && !SS_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      rx_done      <= 1'b0;
      wait_tx      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state != IDLE && SS_n) begin
        // Deselect aborts whatever is in flight; rd_addr_seen survives a dropped read.
        state   <= IDLE;
        cnt     <= '0;
        rx_done <= 1'b0;
        wait_tx <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!SS_n) begin
              state   <= CHK_CMD;
              cnt     <= '0;
              rx_done <= 1'b0;
              wait_tx <= 1'b0;
            end
          end
          CHK_CMD: begin
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!rx_done) begin
              if (cnt == LAST) begin
                rx_data  <= {shreg, MOSI};
                rx_valid <= 1'b1;
                rx_done  <= 1'b1;
                cnt      <= '0;
                if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                if (state == READ_DATA) wait_tx      <= 1'b1;
              end else begin
                shreg <= {shreg[DATA_W-1:0], MOSI};
                cnt   <= cnt + 1'b1;
              end
            end else if (state == READ_DATA) begin
              if (tx_load) wait_tx      <= 1'b0;
              if (tx_last) rd_addr_seen <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .abort (SS_n),
    .load  (tx_load),
    .data  (tx_data),
    .miso  (MISO),
    .done  (tx_last)
  );

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: per-cycle vector table plus hand-written reset/strobe sequences.
module tb_spi_slave_if;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          SS_n;
  logic          MOSI;
  logic          MISO;
  logic [DW+1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;

  int n_cmp = 0;
  int n_bad = 0;

  spi_slave_if #(.DATA_W(DW), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  // Inputs applied for one cycle; expected outputs seen just after that cycle's closing edge.
  typedef struct {
    logic          rst;
    logic          ss_n;
    logic          mosi;
    logic          txv;
    logic [DW-1:0] txd;
    logic          miso;
    logic          rxv;
    logic [DW+1:0] rxd;
  } vec_t;

  vec_t          tv[$];
  logic [DW+1:0] last_rx;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic void push(input logic r, input logic ss, input logic mo, input logic txv,
                               input logic [DW-1:0] txd, input logic miso, input logic rxv,
                               input logic [DW+1:0] rxd);
    vec_t v;
    v.rst = r; v.ss_n = ss; v.mosi = mo; v.txv = txv; v.txd = txd;
    v.miso = miso; v.rxv = rxv; v.rxd = rxd;
    tv.push_back(v);
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) push(0, 1, 0, 0, '0, 0, 0, last_rx);
  endfunction

  function automatic void hold(input int n, input logic txv, input logic [DW-1:0] txd);
    for (int i = 0; i < n; i++) push(0, 0, 0, txv, txd, 0, 0, last_rx);
  endfunction

  // Select cycle, selector bit, then DW+2 frame bits MSB first; strobe on the last bit.
  function automatic void frame(input logic sel, input logic [DW+1:0] val);
    push(0, 0, 0, 0, '0, 0, 0, last_rx);
    push(0, 0, sel, 0, '0, 0, 0, last_rx);
    for (int i = DW+1; i > 0; i--) push(0, 0, val[i], 0, '0, 0, 0, last_rx);
    push(0, 0, val[0], 0, '0, 0, 1, val);
    last_rx = val;
  endfunction

  // n frame bits, then SS_n rises together with the next bit.
  function automatic void partial(input logic sel, input logic [DW+1:0] val, input int n);
    push(0, 0, 0, 0, '0, 0, 0, last_rx);
    push(0, 0, sel, 0, '0, 0, 0, last_rx);
    for (int j = 0; j < n; j++) push(0, 0, val[DW+1-j], 0, '0, 0, 0, last_rx);
    push(0, 1, val[DW+1-n], 0, '0, 0, 0, last_rx);
  endfunction

  // tx_valid cycle then nbits-1 further bits; a full word also expects MISO back at 0.
  function automatic void tx(input logic [DW-1:0] d, input int nbits);
    push(0, 0, 0, 1, d, d[DW-1], 0, last_rx);
    for (int i = DW-2; i >= DW-nbits; i--) push(0, 0, 0, 0, '0, d[i], 0, last_rx);
    if (nbits == DW) push(0, 0, 0, 0, '0, 0, 0, last_rx);
  endfunction

  initial begin
    logic [DW+3:0] seq;
    int            strobes;

    // ---- vector table ----
    last_rx = 10'h2A5;
    frame(0, 10'h0A5); idle(1);                               // write address
    frame(1, 10'h203); idle(1);                               // read address
    frame(1, 10'h300); hold(2, 0, '0); tx(8'hC3, 8);          // read data, reply 2 cycles later
    hold(2, 1, 8'hFF); idle(1);                               // late tx_valid ignored
    frame(1, 10'h3FF); hold(1, 1, 8'hAA); hold(2, 0, '0); idle(1); // seen cleared -> READ_ADD, no tx
    partial(0, 10'h0F0, 6);                                   // abort after 6 bits
    frame(0, 10'h15A); idle(1);
    frame(1, 10'h3AA); tx(8'hFF, 3); idle(1);                 // abort after 3 MISO bits
    frame(1, 10'h3BB); hold(1, 0, '0); tx(8'h5A, 8); idle(1); // still READ_DATA
    partial(0, 10'h2C3, 9);                                   // SS_n rises on the final bit
    frame(0, 10'h0C3); idle(1);
    frame(1, 10'h2F0); idle(1);
    frame(1, 10'h311); tx(8'h96, 4);
    push(1, 0, 1, 0, '0, 0, 0, 10'h000);                      // reset mid-transmit
    last_rx = '0;
    idle(1);
    frame(1, 10'h3E7); hold(1, 1, 8'h81); hold(1, 0, '0); idle(1); // seen reset -> READ_ADD

    // ---- reset ----
    rst = 1'b1; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b0; tx_data = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst_miso", c, 32'(MISO), 32'd0);
      chk("rst_rxv", c, 32'(rx_valid), 32'd0);
      chk("rst_rxd", c, 32'(rx_data), 32'd0);
      chk("rst_state", c, 32'(dut.state), 32'(spi_pkg::IDLE));
    end
    @(negedge clk); rst = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    @(posedge clk); #1;

    // ---- single strobe per frame, SS_n held low after completion ----
    seq = {1'b0, 1'b0, 10'h2A5};
    strobes = 0;
    for (int i = DW+3; i >= -3; i--) begin
      @(negedge clk); SS_n = 1'b0; MOSI = (i >= 0) ? seq[i] : 1'b1;
      @(posedge clk); #1;
      if (rx_valid) begin
        strobes++;
        chk("strobe_rxd", i, 32'(rx_data), 32'h2A5);
      end
      chk("strobe_miso", i, 32'(MISO), 32'd0);
    end
    chk("strobe_count", 0, 32'(strobes), 32'd1);
    @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
    @(posedge clk); #1;

    // ---- apply table ----
    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      rst = tv[k].rst; SS_n = tv[k].ss_n; MOSI = tv[k].mosi;
      tx_valid = tv[k].txv; tx_data = tv[k].txd;
      @(posedge clk); #1;
      chk("miso", k, 32'(MISO), 32'(tv[k].miso));
      chk("rx_valid", k, 32'(rx_valid), 32'(tv[k].rxv));
      chk("rx_data", k, 32'(rx_data), 32'(tv[k].rxd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
